pio_event_sequencer: RTL and testbench

Avalon-MM master that owns the button/switch PIO slave's register port. It programs the interrupt mask after reset and on request. On each PIO interrupt it reads the edge-capture register, clears it, and samples the live input level. It then pushes one {capture, level} event into a small show-ahead FIFO for downstream logic, so the CPU never has to service the PIO itself.

---
 rtl/pio_ctrl_pkg.sv | 37 +++
 rtl/pio_evt_fifo.sv | 65 ++++++
 rtl/pio_event_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pio_event_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pio_ctrl_pkg
// Shared definitions for the button/switch PIO event sequencer:
//   - PIO register addresses (DATA, MASK, EDGE)
//   - sequencer state encoding
//   - small decode helpers used by the sequencer's bus output logic
// No ports; imported with "import pio_ctrl_pkg::*;".
// ---------------------------------------------------------------------------
package pio_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    LOAD,
    RD_CAP,
    CAP_WAIT,
    CLR,
    RD_DAT,
    DAT_WAIT,
    PUSH
  } pio_state_t;

  // States that put a cycle on the PIO bus
  function automatic logic state_uses_bus(pio_state_t s);
    return (s == INIT) || (s == LOAD) || (s == RD_CAP) || (s == CLR) || (s == RD_DAT);
  endfunction

  // States whose bus cycle is a write
  function automatic logic state_is_write(pio_state_t s);
    return (s == INIT) || (s == LOAD) || (s == CLR);
  endfunction

endpackage

// File: rtl/pio_evt_fifo.sv
// ---------------------------------------------------------------------------
// pio_evt_fifo
// Show-ahead FIFO for PIO events. The head entry is presented on pop_data
// whenever empty=0 (zero otherwise); a pop removes it at the clock edge.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push, push_data       write request and data
//   pop                   remove head (ignored while empty)
//   pop_data              head entry
//   full, empty           occupancy flags
// ---------------------------------------------------------------------------
module pio_evt_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the empty flag masks stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_event_sequencer.sv
// ---------------------------------------------------------------------------
// pio_event_sequencer
// Avalon-MM master that owns the button/switch PIO register port. Writes the
// irq mask after reset and on request; on each PIO interrupt reads EDGE,
// clears it, reads DATA and queues one {capture, level} event.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   pio_address/chipselect/
//   pio_write_n/pio_writedata    registered PIO bus outputs
//   pio_readdata, pio_irq        PIO read data (1-cycle latency), interrupt
//   cfg_mask, cfg_mask_load      new mask value and its load pulse
//   evt_valid/ready/capture/level show-ahead event stream
//   overflow, overflow_clr       sticky drop flag and its clear
//   busy                         sequencer not idle
// ---------------------------------------------------------------------------
module pio_event_sequencer #(
  parameter int               WIDTH      = 5,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] MASK_INIT  = 5'h1F
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_load,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_capture,
  output logic [WIDTH-1:0] evt_level,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);

  import pio_ctrl_pkg::*;

  pio_state_t       state;
  pio_state_t       state_next;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] mask_latch;
  logic             mask_pending;
  logic [WIDTH-1:0] rd_bits;
  logic             unused_readdata_bits;

  logic             cs_next;
  logic             write_n_next;
  logic [1:0]       addr_next;
  logic [31:0]      wdata_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2*WIDTH-1:0] fifo_head;

  assign rd_bits              = pio_readdata[WIDTH-1:0];
  assign unused_readdata_bits = ^pio_readdata[31:WIDTH];

  // Next-state logic. INIT holds for one extra cycle so that its mask write
  // is actually presented on the bus: it leaves only once chipselect is up.
  always_comb begin
    state_next = state;
    case (state)
      INIT:     if (pio_chipselect) state_next = IDLE;
      IDLE: begin
        if (mask_pending)  state_next = LOAD;
        else if (pio_irq)  state_next = RD_CAP;
      end
      LOAD:     state_next = IDLE;
      RD_CAP:   state_next = CAP_WAIT;
      CAP_WAIT: state_next = (rd_bits == '0) ? IDLE : CLR;
      CLR:      state_next = RD_DAT;
      RD_DAT:   state_next = DAT_WAIT;
      DAT_WAIT: state_next = PUSH;
      PUSH:     state_next = IDLE;
      default:  state_next = INIT;
    endcase
  end

  // Bus cycle for the state about to be entered, so the registered outputs
  // line up with the state register. CLR is only reached from CAP_WAIT, so
  // the live read data is exactly the value cap is latching in that cycle.
  always_comb begin
    cs_next      = state_uses_bus(state_next);
    write_n_next = ~state_is_write(state_next);
    addr_next    = ADDR_DATA;
    wdata_next   = '0;
    case (state_next)
      INIT: begin
        addr_next               = ADDR_MASK;
        wdata_next[WIDTH-1:0]   = MASK_INIT;
      end
      LOAD: begin
        addr_next               = ADDR_MASK;
        wdata_next[WIDTH-1:0]   = mask_latch;
      end
      RD_CAP:  addr_next = ADDR_EDGE;
      CLR: begin
        addr_next               = ADDR_EDGE;
        wdata_next[WIDTH-1:0]   = rd_bits;
      end
      RD_DAT:  addr_next = ADDR_DATA;
      default: ;
    endcase
  end

  // Sequencer state, registered bus outputs and captured data. A fresh
  // cfg_mask_load beats the clear in LOAD so a late request is not lost.
  // Overflow set beats overflow_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= ADDR_DATA;
      pio_writedata  <= '0;
      busy           <= 1'b1;
      cap            <= '0;
      level          <= '0;
      mask_latch     <= MASK_INIT;
      mask_pending   <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_next;
      pio_chipselect <= cs_next;
      pio_write_n    <= write_n_next;
      pio_address    <= addr_next;
      pio_writedata  <= wdata_next;
      busy           <= (state_next != IDLE);

      if (cfg_mask_load) begin
        mask_latch   <= cfg_mask;
        mask_pending <= 1'b1;
      end else if (state == LOAD) begin
        mask_pending <= 1'b0;
      end

      if (state == CAP_WAIT) cap   <= rd_bits;
      if (state == DAT_WAIT) level <= rd_bits;

      if ((state == PUSH) && fifo_full && !evt_ready) overflow <= 1'b1;
      else if (overflow_clr)                          overflow <= 1'b0;
    end
  end

  assign fifo_push   = (state == PUSH);
  assign fifo_pop    = evt_valid & evt_ready;
  assign evt_valid   = ~fifo_empty;
  assign evt_capture = fifo_head[2*WIDTH-1:WIDTH];
  assign evt_level   = fifo_head[WIDTH-1:0];

  pio_evt_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({cap, level}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pio_event_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pio_event_sequencer
// Bench for pio_event_sequencer: a behavioural PIO slave, an event-level
// reference queue, directed scenarios and a randomized tail.
// ---------------------------------------------------------------------------
module tb_pio_event_sequencer;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             pio_irq;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_mask_load;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_capture;
  logic [WIDTH-1:0] evt_level;
  logic             overflow;
  logic             overflow_clr;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_event_sequencer #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH),
    .MASK_INIT  (5'h1F)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .pio_irq        (pio_irq),
    .cfg_mask       (cfg_mask),
    .cfg_mask_load  (cfg_mask_load),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_capture    (evt_capture),
    .evt_level      (evt_level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .busy           (busy)
  );

  // Behavioural PIO slave: edge capture, mask, registered read data
  logic [WIDTH-1:0] pio_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [31:0]      rdata_q;
  logic             force_zero;

  assign pio_readdata = rdata_q;
  assign pio_irq      = |(edge_reg & mask_reg);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_reg <= '0;
      mask_reg <= '0;
      rdata_q  <= '0;
      prev_in  <= pio_in;
    end else begin
      rdata_q <= '0;
      if (pio_chipselect && pio_write_n) begin
        case (pio_address)
          2'd0:    rdata_q <= 32'(pio_in);
          2'd2:    rdata_q <= 32'(mask_reg);
          2'd3:    rdata_q <= force_zero ? 32'h0 : 32'(edge_reg);
          default: rdata_q <= '0;
        endcase
      end
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) edge_reg <= '0;
      else edge_reg <= edge_reg | (pio_in & ~prev_in);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_reg <= pio_writedata[WIDTH-1:0];
      prev_in <= pio_in;
    end
  end

  // Reference: every completed EDGE/DATA read pair becomes one event in a
  // bounded queue; consumer pops first, then the event lands or is dropped.
  typedef struct packed {
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] lvl;
  } evt_t;

  evt_t             exp_q[$];
  evt_t             pend;
  int               pend_cnt;
  logic             exp_ovf;
  logic             ovf_set;
  logic [WIDTH-1:0] last_cap;
  logic [34:0]      bus_log[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_ovf  = 1'b0;
      pend_cnt = 0;
      last_cap = '0;
    end else begin
      if (exp_q.size() > 0 && evt_ready) void'(exp_q.pop_front());
      ovf_set = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(pend);
          else ovf_set = 1'b1;
        end
      end
      if (ovf_set) exp_ovf = 1'b1;
      else if (overflow_clr) exp_ovf = 1'b0;
      if (pio_chipselect) begin
        bus_log.push_back({~pio_write_n, pio_address, pio_write_n ? 32'h0 : pio_writedata});
        if (pio_write_n && pio_address == 2'd3) last_cap = force_zero ? '0 : edge_reg;
        if (pio_write_n && pio_address == 2'd0) begin
          pend     = '{cap: last_cap, lvl: pio_in};
          pend_cnt = 2;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkModel();
    checkOutput("evt_valid", evt_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      checkOutput("evt_capture", evt_capture, exp_q[0].cap);
      checkOutput("evt_level", evt_level, exp_q[0].lvl);
    end else begin
      checkOutput("evt_capture_empty", evt_capture, 0);
      checkOutput("evt_level_empty", evt_level, 0);
    end
    checkOutput("overflow", overflow, exp_ovf);
  endtask

  task automatic tick();
    @(negedge clk);
    checkModel();
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] in_val, input logic ready, input logic clr);
    pio_in       = in_val;
    evt_ready    = ready;
    overflow_clr = clr;
  endtask

  function automatic int countWrites(input int mark, input logic [1:0] addr);
    int n = 0;
    for (int i = mark; i < bus_log.size(); i++)
      if (bus_log[i][34:32] == {1'b1, addr}) n++;
    return n;
  endfunction

  task automatic waitIrq(input string tag);
    int n = 0;
    while (!pio_irq && n < 12) begin tick(); n++; end
    checkOutput(tag, pio_irq, 1);
  endtask

  task automatic drainAll();
    int n = 0;
    evt_ready = 1'b1;
    while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
    evt_ready = 1'b0;
    checkOutput("drain_done", evt_valid, 0);
  endtask

  task automatic pulseMask(input logic [WIDTH-1:0] m);
    cfg_mask      = m;
    cfg_mask_load = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mark;
    int n;
    int irq_drop;
    logic load_saw_valid;
    logic [WIDTH-1:0] vals [6];
    logic [34:0] exp_seq [6];

    applyStimulus('0, 1'b0, 1'b0);
    cfg_mask      = '0;
    cfg_mask_load = 1'b0;
    force_zero    = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_cs", pio_chipselect, 0);
    checkOutput("rst_write_n", pio_write_n, 1);
    checkOutput("rst_addr", pio_address, 0);
    checkOutput("rst_wdata", pio_writedata, 0);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_capture", evt_capture, 0);
    checkOutput("rst_level", evt_level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_busy", busy, 1);

    $display("[TB] mask write after reset release");
    mark    = bus_log.size();
    reset_n = 1'b1;
    tick();
    checkOutput("init_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b1, 1'b0, 2'd2, 32'h1F});
    checkOutput("init_busy_hi", busy, 1);
    tick();
    checkOutput("init_busy_lo", busy, 0);
    checkOutput("init_cs_lo", pio_chipselect, 0);
    repeat (3) tick();
    checkOutput("init_nwrites", bus_log.size() - mark, 1);
    checkOutput("init_log", bus_log[mark], {1'b1, 2'd2, 32'h1F});

    $display("[TB] single edge on bit 2");
    applyStimulus(5'h04, 1'b0, 1'b0);
    waitIrq("irq_bit2");
    n = 0;
    irq_drop = -1;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
      if (!pio_irq && irq_drop < 0) irq_drop = n;
    end
    checkOutput("irq_drop_delay", irq_drop, 4);
    checkOutput("evt_latency", n, 7);
    checkOutput("bit2_capture", evt_capture, 5'h04);
    checkOutput("bit2_level", evt_level, 5'h04);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;

    $display("[TB] mask load during service");
    applyStimulus(5'h05, 1'b0, 1'b0);
    waitIrq("irq_bit0");
    tick();
    tick();
    mark = bus_log.size();
    pulseMask(5'h03);
    n = 0;
    while (countWrites(mark, 2'd3) == 0 && n < 10) begin tick(); n++; end
    checkOutput("clr_seen", countWrites(mark, 2'd3), 1);
    pio_in = 5'h07;
    load_saw_valid = 1'b0;
    repeat (20) begin
      tick();
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) load_saw_valid = evt_valid;
    end
    checkOutput("load_after_push", load_saw_valid, 1);
    exp_seq[0] = {1'b1, 2'd3, 32'h01};
    exp_seq[1] = {1'b0, 2'd0, 32'h00};
    exp_seq[2] = {1'b1, 2'd2, 32'h03};
    exp_seq[3] = {1'b0, 2'd3, 32'h00};
    exp_seq[4] = {1'b1, 2'd3, 32'h02};
    exp_seq[5] = {1'b0, 2'd0, 32'h00};
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("load_seq%0d", i), (mark + i < bus_log.size()) ? bus_log[mark + i] : '1, exp_seq[i]);
    drainAll();

    $display("[TB] fill FIFO and overflow");
    pulseMask(5'h1F);
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      vals[k] = 5'($urandom_range(1, 31));
      applyStimulus('0, 1'b0, 1'b0);
      tick();
      pio_in = vals[k];
      repeat (12) tick();
    end
    checkOutput("ovf_set", overflow, 1);
    checkOutput("full_head", evt_capture, vals[0]);
    applyStimulus('0, 1'b0, 1'b1);
    tick();
    overflow_clr = 1'b0;
    checkOutput("ovf_clr", overflow, 0);
    vals[5] = 5'($urandom_range(1, 31));
    pio_in  = vals[5];
    waitIrq("irq_full_pop");
    repeat (6) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (3) tick();
    checkOutput("no_drop_with_pop", overflow, 0);
    for (int k = 1; k < 6; k++) begin
      if (k == 4) continue;
      checkOutput($sformatf("drain_cap%0d", k), evt_capture, vals[k]);
      checkOutput($sformatf("drain_lvl%0d", k), evt_level, vals[k]);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checkOutput("fifo_empty_after", evt_valid, 0);

    $display("[TB] spurious interrupt");
    force_zero = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    tick();
    mark   = bus_log.size();
    pio_in = 5'h0A;
    repeat (15) tick();
    checkOutput("spur_no_clr", countWrites(mark, 2'd3), 0);
    checkOutput("spur_no_push", evt_valid, 0);
    force_zero = 1'b0;
    repeat (12) tick();
    checkOutput("spur_recover", evt_capture, 5'h0A);

    $display("[TB] reset during CLR");
    applyStimulus('0, 1'b0, 1'b0);
    tick();
    pio_in = 5'h11;
    n = 0;
    while (!(pio_chipselect && !pio_write_n && pio_address == 2'd3) && n < 15) begin tick(); n++; end
    checkOutput("clr_reached", {pio_chipselect, pio_write_n, pio_address}, {1'b1, 1'b0, 2'd3});
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b1 ^ 1'b1, 1'b1, 2'd0, 32'h0});
    checkOutput("mid_rst_valid", evt_valid, 0);
    checkOutput("mid_rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    mark    = bus_log.size();
    reset_n = 1'b1;
    tick();
    checkOutput("reinit_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b1, 1'b0, 2'd2, 32'h1F});
    repeat (3) tick();
    checkOutput("reinit_nwrites", countWrites(mark, 2'd2), 1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) pio_in = 5'($urandom);
      evt_ready    = ($urandom_range(0, 2) == 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    overflow_clr = 1'b0;
    repeat (10) tick();
    drainAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
